alu_result_display: RTL

- Output stage directly downstream of the shift/ALU datapath top.
- Consumes the 5-bit ALU Result and the 4-bit ALUFlags, captures them on a strobe and converts the result to sign plus two BCD digits using a sequential double-dabble.
- Time-multiplexes four seven-segment digits: flags, sign, tens, units.
- Keeps the last converted value on the display while a new conversion runs.

---
 rtl/alu_disp_pkg.sv | 25 ++
 rtl/alu_result_display_seg7_hex.sv | 31 +++
 rtl/alu_result_display.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_disp_pkg.sv
// Shared constants for the ALU result display: FSM state encodings,
// special segment glyphs, digit positions and the double-dabble adjust step.
package alu_disp_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Digit positions on the display (an[0] is the rightmost digit)
  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_SIGN  = 2'd2;
  localparam logic [1:0] DIG_FLAGS = 2'd3;

  // Double-dabble correction: a BCD digit of 5 or more gets +3 before shifting
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/alu_result_display_seg7_hex.sv
// 4-bit value to active-low seven-segment hex glyph {g,f,e,d,c,b,a}.
module seg7_hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup of the hex glyph
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// ALU result display: captures result/flags on a strobe, converts the
// magnitude to two BCD digits with a sequential double-dabble, and scans
// four active-low seven-segment digits (flags, sign, tens, units).
// Optional macro ALU_DISP_LZ_BLANK_EN: when defined, a tens digit of 0 is
// shown blank instead of '0'.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int REFRESH_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] result,
  input  logic [3:0]       flags,
  input  logic             signed_mode,
  output logic             busy,
  output logic             valid,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       iter_q, iter_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  // Tens needs only 3 bits: with WIDTH <= 6 the value never exceeds 63.
  logic [6:0]       bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic [3:0]       flags_q, flags_d;

  logic [3:0]       disp_units_q, disp_units_d;
  logic [3:0]       disp_tens_q, disp_tens_d;
  logic             disp_sign_q, disp_sign_d;
  logic [3:0]       disp_flags_q, disp_flags_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [3:0]       hex_in    [3];
  logic [6:0]       hex_glyph [3];

  // Capture, double-dabble iterations and shadow-register load
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    sign_d       = sign_q;
    flags_d      = flags_q;
    disp_units_d = disp_units_q;
    disp_tens_d  = disp_tens_q;
    disp_sign_d  = disp_sign_q;
    disp_flags_d = disp_flags_q;
    valid_d      = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          if (signed_mode && result[WIDTH-1]) begin
            // Most negative value maps onto itself, read as unsigned magnitude
            bin_d  = (~result) + {{(WIDTH-1){1'b0}}, 1'b1};
            sign_d = 1'b1;
          end else begin
            bin_d  = result;
            sign_d = 1'b0;
          end
          flags_d = flags;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // Tens is at most 3 before any shift, so only units ever needs +3
        bcd_d  = {bcd_q[5:4], add3(bcd_q[3:0]), bin_q[WIDTH-1]};
        bin_d  = bin_q << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(WIDTH - 1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        disp_units_d = bcd_q[3:0];
        disp_tens_d  = {1'b0, bcd_q[6:4]};
        disp_sign_d  = sign_q;
        disp_flags_d = flags_q;
        valid_d      = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hex_in[0] = disp_units_q;
  assign hex_in[1] = disp_tens_q;
  assign hex_in[2] = disp_flags_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hex
      seg7_hex u_hex (
        .hex (hex_in[gi]),
        .seg (hex_glyph[gi])
      );
    end
  endgenerate

  // Refresh counter, digit index and the registered an/seg pair
  always_comb begin
    ref_cnt_d = ref_cnt_q + CNT_W'(1);
    digit_d   = digit_q;
    if (ref_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      digit_d   = digit_q + 2'd1;
    end
    an_d  = ~(4'b0001 << digit_q);
    seg_d = SEG_BLANK;
    case (digit_q)
      DIG_UNITS: seg_d = hex_glyph[0];
      DIG_TENS: begin
`ifdef ALU_DISP_LZ_BLANK_EN
        seg_d = (disp_tens_q == 4'd0) ? SEG_BLANK : hex_glyph[1];
`else
        seg_d = hex_glyph[1];
`endif
      end
      DIG_SIGN:  seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
      DIG_FLAGS: seg_d = hex_glyph[2];
      default:   seg_d = SEG_BLANK;
    endcase
    if (!valid_q) begin
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
    end
  end

  // State and datapath registers, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      iter_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      sign_q       <= 1'b0;
      flags_q      <= '0;
      disp_units_q <= '0;
      disp_tens_q  <= '0;
      disp_sign_q  <= 1'b0;
      disp_flags_q <= '0;
      valid_q      <= 1'b0;
      ref_cnt_q    <= '0;
      digit_q      <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      sign_q       <= sign_d;
      flags_q      <= flags_d;
      disp_units_q <= disp_units_d;
      disp_tens_q  <= disp_tens_d;
      disp_sign_q  <= disp_sign_d;
      disp_flags_q <= disp_flags_d;
      valid_q      <= valid_d;
      ref_cnt_q    <= ref_cnt_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule
